// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: funct3 codes, FSM states and decode helpers shared by the multiply/divide unit
package muldiv_unit_pkg;
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction
  function automatic logic sel_hi(input logic [2:0] f);
    return f[2] ? f[1] : (f[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/writeback handshake between issue logic, the unit and the register file
interface muldiv_unit_if #(parameter int XLEN = 32) ();
  logic            In_Valid;
  logic            In_Ready;
  logic [2:0]      Funct3;
  logic [4:0]      Rd_Addr_In;
  logic [XLEN-1:0] Rs1_Data;
  logic [XLEN-1:0] Rs2_Data;
  logic            Out_Valid;
  logic            Out_Ready;
  logic [4:0]      Rd_Addr;
  logic [XLEN-1:0] Rd_Data;
  logic            Busy;
  modport master (
    output In_Valid, Funct3, Rd_Addr_In, Rs1_Data, Rs2_Data, Out_Ready,
    input  In_Ready, Out_Valid, Rd_Addr, Rd_Data, Busy
  );
  modport slave (
    input  In_Valid, Funct3, Rd_Addr_In, Rs1_Data, Rs2_Data, Out_Ready,
    output In_Ready, Out_Valid, Rd_Addr, Rd_Data, Busy
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring-divide trial subtract
module muldiv_step #(parameter int XLEN = 32) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   opb,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;
  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb} : '0);
    diff  = {1'b0, acc_i[2*XLEN-1:XLEN-1]} - {2'b00, opb};
    acc_o = is_div ? {diff[XLEN+1] ? acc_i[2*XLEN-2:XLEN-1] : diff[XLEN-1:0], acc_i[XLEN-2:0], ~diff[XLEN+1]}
                   : {sum, acc_i[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide feeding a register-file write port without write enable
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic         Clk,
  input logic         Reset,
  muldiv_unit_if.slave bus
);
  localparam int CYCLES = XLEN / STEPS_PER_CYCLE;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic [2*XLEN-1:0] chain [STEPS_PER_CYCLE+1];
  logic [XLEN-1:0]   a, b, mag_a, mag_b, fast_res, mul_w, div_w, fix_res;
  logic [2*XLEN-1:0] mul_full;
  logic              sa, sb, div_zero, ovf, fast;
  assign chain[0] = acc_q;
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div(is_div(f3_q)),
      .opb   (opb_q),
      .acc_i (chain[g]),
      .acc_o (chain[g+1])
    );
  end
  // Operand decode: signed sources are reduced to magnitudes, sign fixed up after the loop
  always_comb begin
    a        = bus.Rs1_Data;
    b        = bus.Rs2_Data;
    sa       = a[XLEN-1] & (bus.Funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sb       = b[XLEN-1] & (bus.Funct3 inside {F3_MULH, F3_DIV, F3_REM});
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    div_zero = is_div(bus.Funct3) && (b == '0);
    ovf      = (bus.Funct3 inside {F3_DIV, F3_REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = div_zero || ovf;
    fast_res = div_zero ? (bus.Funct3[1] ? a : '1) : (bus.Funct3[1] ? '0 : a);
    mul_full = neg_q ? -acc_q : acc_q;
    mul_w    = sel_hi(f3_q) ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
    div_w    = sel_hi(f3_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    fix_res  = is_div(f3_q) ? (neg_q ? -div_w : div_w) : mul_w;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: if (bus.In_Valid) begin
        f3_d      = bus.Funct3;
        rd_d      = bus.Rd_Addr_In;
        neg_d     = (is_div(bus.Funct3) && bus.Funct3[1]) ? sa : sa ^ sb;
        opb_d     = mag_b;
        acc_d     = {{XLEN{1'b0}}, mag_a};
        cnt_d     = '0;
        rd_data_d = fast ? fast_res : rd_data_q;
        state_d   = fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        acc_d   = chain[STEPS_PER_CYCLE];
        cnt_d   = (cnt_q == CW'(CYCLES-1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(CYCLES-1)) ? S_FIX : S_CALC;
      end
      S_FIX: begin
        rd_data_d = fix_res;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = bus.Out_Ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      rd_data_q <= rd_data_d;
    end
  end
  // No write enable downstream, so the address itself is the write strobe
  assign bus.Rd_Addr   = (state_q == S_DONE && bus.Out_Ready) ? rd_q : 5'd0;
  assign bus.In_Ready  = (state_q == S_IDLE);
  assign bus.Out_Valid = (state_q == S_DONE);
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.Rd_Data   = rd_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench, directed RV32M cases plus random ops against an arithmetic model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          lat;
    int          acc_cyc;
  } exp_t;
  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_hold = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7};
    return ($urandom_range(3) == 0) ? sp[$urandom_range(4)] : $urandom;
  endfunction
  task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.In_Ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.In_Ready) begin
      vectors++;
      errors++;
      $display("FAIL issue_timeout: in_ready=0 expected 1 within 300 cycles");
    end else begin
      bus.In_Valid   = 1'b1;
      bus.Funct3     = f;
      bus.Rd_Addr_In = rd;
      bus.Rs1_Data   = a;
      bus.Rs2_Data   = b;
      @(posedge clk);
      #1;
      bus.In_Valid = 1'b0;
      e.data    = model(f, a, b);
      e.rd      = rd;
      e.lat     = latency(f, a, b);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    bus.Out_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.Out_Ready = rdy_hold ? 1'b0 : rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
    end
  end
  initial begin
    exp_t e;
    logic prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_ov = 1'b0;
      else begin
        if (bus.Out_Valid && !prev_ov && exp_q.size() != 0)
          chk("latency", 32'(cyc - exp_q[0].acc_cyc + 1), 32'(exp_q[0].lat));
        if (bus.Out_Valid && bus.Out_Ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_write: rd_addr=%0d data=%h, expected no write", bus.Rd_Addr, bus.Rd_Data);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", bus.Rd_Data, e.data);
            chk("rd_addr", 32'(bus.Rd_Addr), 32'(e.rd));
          end
        end else if (bus.Rd_Addr !== 5'd0) chk("rd_addr_idle", 32'(bus.Rd_Addr), 32'd0);
        prev_ov = bus.Out_Valid;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    bus.In_Valid   = 1'b0;
    bus.Funct3     = 3'd0;
    bus.Rd_Addr_In = 5'd0;
    bus.Rs1_Data   = 32'd0;
    bus.Rs2_Data   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.In_Ready), 32'd1);
    chk("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
    chk("rst_rd_addr", 32'(bus.Rd_Addr), 32'd0);
    chk("rst_rd_data", bus.Rd_Data, 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(3'd0, 5'd1, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, 5'd2, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 5'd5, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 5'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 5'd7, 32'd100, 32'd7);
    issue(3'd7, 5'd8, 32'd100, 32'd7);
    issue(3'd4, 5'd9, 32'd5, 32'd0);
    issue(3'd7, 5'd10, 32'd5, 32'd0);
    issue(3'd4, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd0, 5'd0, 32'd9, 32'd9);
    drain();
    // Writeback stall: result and index must hold while new requests are refused
    rdy_hold = 1'b1;
    repeat (2) @(posedge clk);
    issue(3'd5, 5'd13, 32'd100, 32'd7);
    n = 0;
    while (!bus.Out_Valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", 32'(bus.Out_Valid), 32'd1);
    bus.In_Valid   = 1'b1;
    bus.Funct3     = 3'd0;
    bus.Rd_Addr_In = 5'd20;
    bus.Rs1_Data   = 32'd2;
    bus.Rs2_Data   = 32'd2;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.Out_Valid), 32'd1);
      chk("stall_rd_data", bus.Rd_Data, 32'd14);
      chk("stall_in_ready", 32'(bus.In_Ready), 32'd0);
    end
    bus.In_Valid = 1'b0;
    rdy_hold = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("stall_back_idle", 32'(bus.Busy), 32'd0);
    // Reset during CALC drops the op with no write
    issue(3'd0, 5'd14, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(bus.In_Ready), 32'd1);
    chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
    chk("rst_mid_out_valid", 32'(bus.Out_Valid), 32'd0);
    repeat (40) @(posedge clk);
    issue(3'd0, 5'd15, 32'd3, 32'd4);
    drain();
    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++)
      issue(3'($urandom_range(7)), 5'($urandom_range(31)), pick(), pick());
    drain();
    rdy_rand = 1'b0;
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
